text_screen_buffer: RTL and testbench
=====================================

Name: text_screen_buffer

Overview:
Parametrised successor to the fixed 80x25 text screen RAM. Stores one 16-bit cell (code point in the low byte, attribute in the high byte) for each position of a COLUMNS x ROWS screen. Adds a command engine that clears the screen, clears one row, or scrolls up one row, while the renderer keeps reading.
Sits between the CPU bus bridge and the text renderer. Single clock domain.

Parameters:
COLUMNS, 80, cells per row (>=1)
ROWS, 25, rows per screen (>=2)
ADDR_WIDTH, 11, cell address width; must satisfy 2^ADDR_WIDTH >= COLUMNS*ROWS
MEM_INIT_FILE, "", hex init file; empty string means all cells start at MEM_INIT_VAL
MEM_INIT_VAL, 16'h0000, init word when no file is given

Ports:
clock  in  1  system clock, rising edge
resetN  in  1  asynchronous active-low reset
rendEnable  in  1  renderer read strobe
rendAddress  in  ADDR_WIDTH  renderer cell address
rendDataOut  out  16  renderer read data
cpuEnable  in  1  CPU access strobe
cpuWriteEnable  in  2  byte write enables (bit0 = code point, bit1 = attribute)
cpuAddress  in  ADDR_WIDTH  CPU cell address
cpuDataIn  in  16  CPU write data
cpuDataOut  out  16  CPU read data
cpuReady  out  1  CPU port accepts accesses (equals not busy)
cmdValid  in  1  command request
cmdReady  out  1  engine idle, command accepted when cmdValid&cmdReady
cmdOp  in  2  00 clear screen, 01 scroll up one row, 10 clear row, 11 reserved (no-op)
cmdRow  in  clog2(ROWS)  target row for clear row
cmdFill  in  16  fill word
busy  out  1  engine active
done  out  1  one-cycle pulse when a command completes

Behaviour:
- CELLS = COLUMNS*ROWS.
- resetN low, asynchronous:
  - rendDataOut = 0, cpuDataOut = 0, busy = 0, done = 0.
  - cmdReady = 1, cpuReady = 1, state = IDLE.
  - Memory contents are not reset.
- Renderer port:
  - Read-only, synchronous, 1-cycle latency: address at edge N gives data after edge N.
  - rendDataOut holds its value when rendEnable = 0.
  - Never stalled.
  - Same-cycle collision with any write to the same address returns the old data.
- CPU port:
  - Active only when cpuReady = 1.
  - cpuEnable with cpuWriteEnable = 0 is a read: 1-cycle latency, and cpuDataOut holds otherwise.
  - Nonzero cpuWriteEnable writes only the enabled bytes. A write does not update cpuDataOut.
  - Writes to addresses >= CELLS are dropped. Reads of those addresses return the stored word.
  - While busy, CPU strobes are ignored entirely (no write, cpuDataOut holds). The bus bridge must wait for cpuReady.
- Command engine: states IDLE, COPY, FILL, DONE. It drives the shared write port.
  - Accept (IDLE, cmdValid=1): latch cmdOp, cmdRow, cmdFill. busy and cmdReady/cpuReady change on the next edge.
  - op 00: FILL with dst = 0..CELLS-1, one cell per cycle, CELLS cycles total.
  - op 10: FILL with dst = cmdRow*COLUMNS .. +COLUMNS-1, COLUMNS cycles. If cmdRow >= ROWS, go straight to DONE with no writes.
  - op 01: COPY, then FILL.
    - COPY reads src = COLUMNS..CELLS-1, one per cycle.
    - Each word is written to src-COLUMNS one cycle after its read.
    - COPY lasts CELLS-COLUMNS+1 cycles: 1 prime cycle plus the pipelined reads and writes.
    - FILL then writes the last row (COLUMNS cycles).
  - op 11: go straight to DONE.
  - DONE lasts one cycle: done = 1 and busy still 1. The next state is IDLE, with busy = 0 and cmdReady = 1.
  - cmdValid during busy is ignored, not queued.
- Reset mid-command: the engine aborts immediately and memory is left partially updated. No done pulse.
- ROWS = 1 is not supported.

Test Plan:
- Default params, no init file: renderer reads addr 0, 1999, 2047 -> all 16'h0000, 1 cycle after strobe.
- CPU write 16'hABCD to addr 5 with WE=2'b01, then read addr 5 -> 16'h00CD. A later WE=2'b10 write of 16'h12FF -> 16'h12CD.
- Clear screen, fill 16'h0720:
  - cmdReady falls 1 cycle after accept; busy is high for exactly 2001 cycles, including DONE.
  - done pulses once.
  - All 2000 cells read 16'h0720; addr 2000 is unchanged.
- Scroll up:
  - Preload cell i = i.
  - Scroll with fill 16'h0000 -> cell 0 = 80, cell 1919 = 1999, cells 1920..1999 = 0.
  - busy lasts 1921+80+1 cycles.
- CPU write strobes during busy are dropped, checked after done. Renderer reads during the scroll return valid old-or-new data, never X.
- resetN asserted mid clear-row 3 -> outputs return to reset values asynchronously, no done pulse, and the next command is accepted normally. Also run COLUMNS=40, ROWS=25, ADDR_WIDTH=10 and repeat the scroll check.

Source files
------------

// File: rtl/text_screen_buffer.sv
// COLUMNS x ROWS text cell RAM with renderer read port, CPU byte-write port
// and a clear / clear-row / scroll-up command engine sharing the write port.
// Ports:
//   clock, resetN : clock and async active-low reset
//   rend*         : renderer read port, 1-cycle latency, never stalled
//   cpu*          : CPU read/byte-write port, serviced only while cpuReady
//   cmd*          : command request with valid/ready handshake
//   busy, done    : engine active level and completion pulse
module text_screen_buffer #(
  parameter int          COLUMNS       = 80,
  parameter int          ROWS          = 25,
  parameter int          ADDR_WIDTH    = 11,
  parameter string       MEM_INIT_FILE = "",
  parameter logic [15:0] MEM_INIT_VAL  = 16'h0000,
  localparam int         ROW_W         = $clog2(ROWS)
) (
  input  logic                  clock,
  input  logic                  resetN,
  input  logic                  rendEnable,
  input  logic [ADDR_WIDTH-1:0] rendAddress,
  output logic [15:0]           rendDataOut,
  input  logic                  cpuEnable,
  input  logic [1:0]            cpuWriteEnable,
  input  logic [ADDR_WIDTH-1:0] cpuAddress,
  input  logic [15:0]           cpuDataIn,
  output logic [15:0]           cpuDataOut,
  output logic                  cpuReady,
  input  logic                  cmdValid,
  output logic                  cmdReady,
  input  logic [1:0]            cmdOp,
  input  logic [ROW_W-1:0]      cmdRow,
  input  logic [15:0]           cmdFill,
  output logic                  busy,
  output logic                  done
);

  localparam int CELLS = COLUMNS * ROWS;
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  localparam logic [ADDR_WIDTH:0] CELLS_X =
    (ADDR_WIDTH + 1)'(CELLS);
  localparam logic [ADDR_WIDTH-1:0] LAST =
    ADDR_WIDTH'(CELLS - 1);
  localparam logic [ADDR_WIDTH-1:0] COLS_A =
    ADDR_WIDTH'(COLUMNS);
  // Copy count and also base address of the last row.
  localparam logic [ADDR_WIDTH-1:0] SPAN =
    ADDR_WIDTH'(CELLS - COLUMNS);
  localparam logic [ADDR_WIDTH-1:0] ONE =
    ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] ZERO = '0;
  localparam logic [ROW_W:0] ROWS_X =
    (ROW_W + 1)'(ROWS);

  typedef enum logic [1:0] {
    IDLE,
    COPY,
    FILL,
    DONE
  } state_t;

  logic [15:0] mem [DEPTH] = '{default: MEM_INIT_VAL};

  state_t state, state_n;

  logic [15:0]           fill_q, fill_n;
  logic [ADDR_WIDTH-1:0] dst_q, dst_n;
  logic [ADDR_WIDTH-1:0] last_q, last_n;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_n;
  logic [15:0]           cpy_q;

  logic                  eng_we;
  logic [ADDR_WIDTH-1:0] eng_addr;
  logic [15:0]           eng_data;

  logic [1:0]            wmask;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [15:0]           wdata;

  logic                  idle;
  logic                  cpu_in_range;
  logic                  cpu_wr;
  logic                  cpu_rd;
  logic                  row_ok;
  logic [ADDR_WIDTH-1:0] row_base;

  assign idle     = (state == IDLE);
  assign busy     = !idle;
  assign done     = (state == DONE);
  assign cmdReady = idle;
  assign cpuReady = idle;

  assign cpu_in_range = {1'b0, cpuAddress} < CELLS_X;
  assign cpu_wr = idle && cpuEnable &&
                  (cpuWriteEnable != 2'b00) &&
                  cpu_in_range;
  assign cpu_rd = idle && cpuEnable &&
                  (cpuWriteEnable == 2'b00);

  // Only evaluated for in-range rows, so the product fits.
  assign row_ok   = {1'b0, cmdRow} < ROWS_X;
  assign row_base = ADDR_WIDTH'(int'(cmdRow) * COLUMNS);

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state  <= IDLE;
      fill_q <= '0;
      dst_q  <= '0;
      last_q <= '0;
      cnt_q  <= '0;
    end else begin
      state  <= state_n;
      fill_q <= fill_n;
      dst_q  <= dst_n;
      last_q <= last_n;
      cnt_q  <= cnt_n;
    end
  end

  always_comb begin
    state_n  = state;
    fill_n   = fill_q;
    dst_n    = dst_q;
    last_n   = last_q;
    cnt_n    = cnt_q;
    eng_we   = 1'b0;
    eng_addr = '0;
    eng_data = '0;
    unique case (state)
      IDLE: begin
        if (cmdValid) begin
          fill_n = cmdFill;
          cnt_n  = '0;
          unique case (1'b1)
            cmdOp == 2'b00: begin
              dst_n   = ZERO;
              last_n  = LAST;
              state_n = FILL;
            end
            cmdOp == 2'b01: begin
              state_n = COPY;
            end
            cmdOp == 2'b10: begin
              dst_n   = row_base;
              last_n  = row_base + COLS_A - ONE;
              state_n = row_ok ? FILL : DONE;
            end
            default: begin
              state_n = DONE;
            end
          endcase
        end
      end
      COPY: begin
        // Cycle 0 only primes the read; later cycles write
        // the word fetched one cycle earlier one row up.
        if (cnt_q != ZERO) begin
          eng_we   = 1'b1;
          eng_addr = cnt_q - ONE;
          eng_data = cpy_q;
        end
        if (cnt_q == SPAN) begin
          dst_n   = SPAN;
          last_n  = LAST;
          state_n = FILL;
        end else begin
          cnt_n = cnt_q + ONE;
        end
      end
      FILL: begin
        eng_we   = 1'b1;
        eng_addr = dst_q;
        eng_data = fill_q;
        if (dst_q == last_q) begin
          state_n = DONE;
        end else begin
          dst_n = dst_q + ONE;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_comb begin
    wmask = 2'b00;
    waddr = cpuAddress;
    wdata = cpuDataIn;
    if (busy) begin
      wmask = {2{eng_we}};
      waddr = eng_addr;
      wdata = eng_data;
    end else if (cpu_wr) begin
      wmask = cpuWriteEnable;
    end
  end

  always_ff @(posedge clock) begin
    if (wmask[0]) mem[waddr][7:0]  <= wdata[7:0];
    if (wmask[1]) mem[waddr][15:8] <= wdata[15:8];
  end

  // Read ahead address wraps harmlessly on the final copy cycle.
  always_ff @(posedge clock) begin
    if (state == COPY) cpy_q <= mem[COLS_A + cnt_q];
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      rendDataOut <= '0;
    end else if (rendEnable) begin
      rendDataOut <= mem[rendAddress];
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      cpuDataOut <= '0;
    end else if (cpu_rd) begin
      cpuDataOut <= mem[cpuAddress];
    end
  end

endmodule

// File: tb/tb_text_screen_buffer.sv
// Directed self-checking bench for text_screen_buffer.
// Covers 80x25 and 40x25 instances.
module tb_text_screen_buffer;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic resetN;

  logic        a_ren;
  logic [10:0] a_raddr;
  logic [15:0] a_rdo;
  logic        a_cen;
  logic [1:0]  a_cwe;
  logic [10:0] a_caddr;
  logic [15:0] a_cdi, a_cdo;
  logic        a_crdy, a_cv, a_cmdrdy;
  logic [1:0]  a_op;
  logic [4:0]  a_row;
  logic [15:0] a_fill;
  logic        a_busy, a_done;

  logic        b_ren;
  logic [9:0]  b_raddr;
  logic [15:0] b_rdo;
  logic        b_cen;
  logic [1:0]  b_cwe;
  logic [9:0]  b_caddr;
  logic [15:0] b_cdi, b_cdo;
  logic        b_crdy, b_cv, b_cmdrdy;
  logic [1:0]  b_op;
  logic [4:0]  b_row;
  logic [15:0] b_fill;
  logic        b_busy, b_done;

  int total = 0;
  int bad = 0;

  text_screen_buffer u_a (
    .clock(clock), .resetN(resetN),
    .rendEnable(a_ren), .rendAddress(a_raddr),
    .rendDataOut(a_rdo),
    .cpuEnable(a_cen), .cpuWriteEnable(a_cwe),
    .cpuAddress(a_caddr), .cpuDataIn(a_cdi),
    .cpuDataOut(a_cdo), .cpuReady(a_crdy),
    .cmdValid(a_cv), .cmdReady(a_cmdrdy),
    .cmdOp(a_op), .cmdRow(a_row), .cmdFill(a_fill),
    .busy(a_busy), .done(a_done)
  );

  text_screen_buffer #(
    .COLUMNS(40), .ROWS(25), .ADDR_WIDTH(10)
  ) u_b (
    .clock(clock), .resetN(resetN),
    .rendEnable(b_ren), .rendAddress(b_raddr),
    .rendDataOut(b_rdo),
    .cpuEnable(b_cen), .cpuWriteEnable(b_cwe),
    .cpuAddress(b_caddr), .cpuDataIn(b_cdi),
    .cpuDataOut(b_cdo), .cpuReady(b_crdy),
    .cmdValid(b_cv), .cmdReady(b_cmdrdy),
    .cmdOp(b_op), .cmdRow(b_row), .cmdFill(b_fill),
    .busy(b_busy), .done(b_done)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic cwr(input int s, input int addr,
                     input logic [15:0] d,
                     input logic [1:0] we);
    @(negedge clock);
    if (s == 0) begin
      a_cen = 1'b1; a_cwe = we;
      a_caddr = addr[10:0]; a_cdi = d;
    end else begin
      b_cen = 1'b1; b_cwe = we;
      b_caddr = addr[9:0]; b_cdi = d;
    end
    @(negedge clock);
    a_cen = 1'b0; a_cwe = 2'b00;
    b_cen = 1'b0; b_cwe = 2'b00;
  endtask

  task automatic crd(input int addr,
                     output logic [15:0] d);
    @(negedge clock);
    a_cen = 1'b1; a_cwe = 2'b00;
    a_caddr = addr[10:0];
    @(negedge clock);
    a_cen = 1'b0;
    d = a_cdo;
  endtask

  task automatic rrd(input int s, input int addr,
                     output logic [15:0] d);
    @(negedge clock);
    if (s == 0) begin
      a_ren = 1'b1; a_raddr = addr[10:0];
    end else begin
      b_ren = 1'b1; b_raddr = addr[9:0];
    end
    @(negedge clock);
    a_ren = 1'b0; b_ren = 1'b0;
    d = (s == 0) ? a_rdo : b_rdo;
  endtask

  task automatic run_cmd(input int s,
                         input logic [1:0] op,
                         input int row,
                         input logic [15:0] fill,
                         input bit stress,
                         output int n, output int dn,
                         output int xs,
                         output logic rdy_after);
    @(negedge clock);
    if (s == 0) begin
      a_cv = 1'b1; a_op = op;
      a_row = row[4:0]; a_fill = fill;
    end else begin
      b_cv = 1'b1; b_op = op;
      b_row = row[4:0]; b_fill = fill;
    end
    @(negedge clock);
    a_cv = 1'b0; b_cv = 1'b0;
    rdy_after = (s == 0) ? a_cmdrdy : b_cmdrdy;
    n = 0; dn = 0; xs = 0;
    while (((s == 0) ? a_busy : b_busy) && n < 6000) begin
      if ((s == 0) ? a_done : b_done) dn++;
      if (stress) begin
        a_ren = 1'b1; a_raddr = 11'(n % 2048);
        a_cen = 1'b1; a_cwe = 2'b11;
        a_caddr = 11'd5; a_cdi = 16'hDEAD;
      end
      n++;
      @(negedge clock);
      if (stress && $isunknown(a_rdo)) xs++;
    end
    a_ren = 1'b0; a_cen = 1'b0; a_cwe = 2'b00;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] d;
    int n, dn, xs, cnt;
    logic r;

    resetN = 1'b0;
    a_ren = 0; a_raddr = 0; a_cen = 0; a_cwe = 0;
    a_caddr = 0; a_cdi = 0; a_cv = 0; a_op = 0;
    a_row = 0; a_fill = 0;
    b_ren = 0; b_raddr = 0; b_cen = 0; b_cwe = 0;
    b_caddr = 0; b_cdi = 0; b_cv = 0; b_op = 0;
    b_row = 0; b_fill = 0;

    repeat (2) @(negedge clock);
    chk("rst_rdo", a_rdo, 16'h0000);
    chk("rst_cdo", a_cdo, 16'h0000);
    chk("rst_busy", a_busy, 1'b0);
    chk("rst_done", a_done, 1'b0);
    chk("rst_cmdrdy", a_cmdrdy, 1'b1);
    chk("rst_cpurdy", a_crdy, 1'b1);
    resetN = 1'b1;

    rrd(0, 0, d);    chk("init0", d, 16'h0000);
    rrd(0, 1999, d); chk("init1999", d, 16'h0000);
    rrd(0, 2047, d); chk("init2047", d, 16'h0000);

    cwr(0, 5, 16'hABCD, 2'b01);
    crd(5, d); chk("we01", d, 16'h00CD);
    cwr(0, 5, 16'h12FF, 2'b10);
    crd(5, d); chk("we10", d, 16'h12CD);
    cwr(0, 2000, 16'h1111, 2'b11);
    crd(2000, d); chk("oob_wr", d, 16'h0000);

    chk("clr_rdy_before", a_cmdrdy, 1'b1);
    run_cmd(0, 2'b00, 0, 16'h0720, 1'b0,
            n, dn, xs, r);
    chk("clr_rdy_after", r, 1'b0);
    chk("clr_busy", n, 2001);
    chk("clr_done", dn, 1);
    cnt = 0;
    for (int i = 0; i < 2000; i++) begin
      rrd(0, i, d);
      if (d !== 16'h0720) cnt++;
    end
    chk("clr_cells", cnt, 0);
    rrd(0, 2000, d); chk("clr_2000", d, 16'h0000);

    rrd(0, 0, d);
    @(negedge clock);
    a_raddr = 11'd2000;
    @(negedge clock);
    chk("rend_hold", a_rdo, 16'h0720);

    for (int i = 0; i < 2000; i++)
      cwr(0, i, 16'(i), 2'b11);
    crd(7, d); chk("pre7", d, 16'd7);

    run_cmd(0, 2'b01, 0, 16'h0000, 1'b1,
            n, dn, xs, r);
    chk("scr_rdy_after", r, 1'b0);
    chk("scr_busy", n, 2002);
    chk("scr_done", dn, 1);
    chk("scr_noX", xs, 0);
    chk("scr_cdo_hold", a_cdo, 16'd7);
    rrd(0, 0, d);    chk("scr0", d, 16'd80);
    rrd(0, 1919, d); chk("scr1919", d, 16'd1999);
    rrd(0, 5, d);    chk("scr_drop5", d, 16'd85);
    cnt = 0;
    for (int i = 0; i < 1920; i++) begin
      rrd(0, i, d);
      if (d !== 16'(i + 80)) cnt++;
    end
    chk("scr_body", cnt, 0);
    cnt = 0;
    for (int i = 1920; i < 2000; i++) begin
      rrd(0, i, d);
      if (d !== 16'h0000) cnt++;
    end
    chk("scr_last", cnt, 0);

    run_cmd(0, 2'b11, 0, 16'h5A5A, 1'b0,
            n, dn, xs, r);
    chk("nop_busy", n, 1);
    chk("nop_done", dn, 1);
    run_cmd(0, 2'b10, 30, 16'h5A5A, 1'b0,
            n, dn, xs, r);
    chk("badrow_busy", n, 1);
    chk("badrow_done", dn, 1);
    rrd(0, 0, d); chk("nop_nowrite", d, 16'd80);

    @(negedge clock);
    a_cv = 1'b1; a_op = 2'b10;
    a_row = 5'd3; a_fill = 16'h5555;
    @(negedge clock);
    a_cv = 1'b0;
    dn = 0;
    for (int i = 0; i < 9; i++) begin
      if (a_done) dn++;
      @(negedge clock);
    end
    #2 resetN = 1'b0;
    #1;
    chk("mid_done_seen", dn, 0);
    chk("mid_busy", a_busy, 1'b0);
    chk("mid_done", a_done, 1'b0);
    chk("mid_cmdrdy", a_cmdrdy, 1'b1);
    chk("mid_cpurdy", a_crdy, 1'b1);
    chk("mid_rdo", a_rdo, 16'h0000);
    chk("mid_cdo", a_cdo, 16'h0000);
    @(negedge clock);
    resetN = 1'b1;
    rrd(0, 248, d); chk("mid_248", d, 16'h5555);
    rrd(0, 249, d); chk("mid_249", d, 16'd329);

    run_cmd(0, 2'b10, 2, 16'h1234, 1'b0,
            n, dn, xs, r);
    chk("row2_rdy_after", r, 1'b0);
    chk("row2_busy", n, 81);
    chk("row2_done", dn, 1);
    rrd(0, 160, d); chk("row2_160", d, 16'h1234);
    rrd(0, 239, d); chk("row2_239", d, 16'h1234);
    rrd(0, 159, d); chk("row2_159", d, 16'd239);
    rrd(0, 240, d); chk("row2_240", d, 16'h5555);

    for (int i = 0; i < 1000; i++)
      cwr(1, i, 16'(i), 2'b11);
    run_cmd(1, 2'b01, 0, 16'hFFFF, 1'b0,
            n, dn, xs, r);
    chk("b_busy", n, 1002);
    chk("b_done", dn, 1);
    rrd(1, 0, d);   chk("b_scr0", d, 16'd40);
    rrd(1, 959, d); chk("b_scr959", d, 16'd999);
    cnt = 0;
    for (int i = 0; i < 960; i++) begin
      rrd(1, i, d);
      if (d !== 16'(i + 40)) cnt++;
    end
    chk("b_body", cnt, 0);
    cnt = 0;
    for (int i = 960; i < 1000; i++) begin
      rrd(1, i, d);
      if (d !== 16'hFFFF) cnt++;
    end
    chk("b_last", cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
